// File: rtl/kgain_if.sv
// -----------------------------------------------------------------------------
// kgain_if: request/result bundle for the serial 2x2 Kalman-gain engine.
//
// Signals (all data signed Q(N-FRAC).FRAC, two's complement):
//   start              1   one-cycle request from the master
//   P11,P12,P21,P22    N   prior covariance P
//   R11,R12,R21,R22    N   measurement noise covariance R
//   busy               1   engine is working on a request
//   done               1   one-cycle pulse, K/sing valid
//   sing               1   det(S)==0 on the last completed run
//   K11,K12,K21,K22    N   Kalman gain, held between done pulses
//
// Modports: master drives the request, slave (the engine) drives the results.
// -----------------------------------------------------------------------------
interface kgain_if #(
  parameter int N = 20
);
  logic                start;
  logic signed [N-1:0] P11, P12, P21, P22;
  logic signed [N-1:0] R11, R12, R21, R22;
  logic                busy;
  logic                done;
  logic                sing;
  logic signed [N-1:0] K11, K12, K21, K22;

  modport master (
    output start, P11, P12, P21, P22, R11, R12, R21, R22,
    input  busy, done, sing, K11, K12, K21, K22
  );

  modport slave (
    input  start, P11, P12, P21, P22, R11, R12, R21, R22,
    output busy, done, sing, K11, K12, K21, K22
  );
endinterface

// File: rtl/kgain_serial.sv
// -----------------------------------------------------------------------------
// kgain_serial: serial 2x2 Kalman gain K = P * (P + R)^-1  (H = I).
//
// Latches P and R on an accepted start, forms S = P + R, det(S), a restoring
// reciprocal of det, the adjugate products P*adj(S), and finally scales them
// by the reciprocal. One shared multiplier pair serves DET, ADJ and SCALE.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (aborts any run)
//   bus   kgain_if.slave: start/P/R in, busy/done/sing/K out
//
// Latency from the accepting edge t0: done is high after edge t0+2*FRAC+12
// (nonsingular) or after edge t0+3 (det==0).
// -----------------------------------------------------------------------------
module kgain_serial #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input logic    clk,
  input logic    rst,
  kgain_if.slave bus
);

  localparam int SW = N + 1;          // S = P + R without wrap
  localparam int DW = 2 * SW + 1;     // det at full internal width
  localparam int AW = 2 * N + 2;      // adjugate products after shift
  localparam int QW = 2 * FRAC + 1;   // reciprocal magnitude bits
  localparam int RW = DW + 1;         // divider remainder
  localparam int MW = AW + 2;         // shared multiplier operand width
  localparam int PW = 2 * MW;         // shared multiplier product width
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [2:0] {IDLE, SUM, DET, DIV, ADJ, SCALE, FIN} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic signed [N-1:0]   p_q    [4];
  logic signed [N-1:0]   r_q    [4];
  logic signed [SW-1:0]  s_q    [4];
  logic signed [DW-1:0]  det_q;
  logic [DW-1:0]         dabs_q;
  logic [RW-1:0]         rem_q;
  logic [QW-1:0]         quo_q;
  logic signed [AW-1:0]  a_q    [4];
  logic signed [N-1:0]   kres_q [4];
  logic signed [N-1:0]   k_q    [4];
  logic                  sing_pend_q;
  logic                  sing_q;
  logic                  busy_q;
  logic                  done_q;

  logic signed [MW-1:0]  ma0, mb0, ma1, mb1;
  logic signed [PW-1:0]  prod0, prod1, pdiff_sh, kraw;
  logic signed [DW-1:0]  det_d;
  logic signed [AW-1:0]  adj_d;
  logic [DW-1:0]         det_abs;
  logic signed [QW:0]    recip;
  logic [RW-1:0]         rem_sh, rem_nx;
  logic                  qbit;

  function automatic logic signed [N-1:0] sat_n(input logic signed [PW-1:0] x);
    // In range when every bit above the N-bit sign position matches the sign.
    if (x[PW-1:N-1] == {(PW-N+1){x[PW-1]}})
      return x[N-1:0];
    else if (x[PW-1])
      return {1'b1, {(N-1){1'b0}}};
    else
      return {1'b0, {(N-1){1'b1}}};
  endfunction

  // Shared multiplier pair: operands chosen by state and product index.
  always_comb begin
    ma0 = '0;
    mb0 = '0;
    ma1 = '0;
    mb1 = '0;
    case (state_q)
      DET: begin
        ma0 = MW'(s_q[0]); mb0 = MW'(s_q[3]);
        ma1 = MW'(s_q[1]); mb1 = MW'(s_q[2]);
      end
      ADJ: begin
        case (cnt_q[1:0])
          2'd0: begin
            ma0 = MW'(p_q[0]); mb0 = MW'(s_q[3]);
            ma1 = MW'(p_q[1]); mb1 = MW'(s_q[2]);
          end
          2'd1: begin
            ma0 = MW'(p_q[1]); mb0 = MW'(s_q[0]);
            ma1 = MW'(p_q[0]); mb1 = MW'(s_q[1]);
          end
          2'd2: begin
            ma0 = MW'(p_q[2]); mb0 = MW'(s_q[3]);
            ma1 = MW'(p_q[3]); mb1 = MW'(s_q[2]);
          end
          default: begin
            ma0 = MW'(p_q[3]); mb0 = MW'(s_q[0]);
            ma1 = MW'(p_q[2]); mb1 = MW'(s_q[1]);
          end
        endcase
      end
      SCALE: begin
        ma0 = MW'(a_q[cnt_q[1:0]]);
        mb0 = MW'(recip);
      end
      default: ;
    endcase
  end

  assign prod0    = ma0 * mb0;
  assign prod1    = ma1 * mb1;
  assign pdiff_sh = (prod0 - prod1) >>> FRAC;
  assign kraw     = prod0 >>> FRAC;
  assign det_d    = DW'(pdiff_sh);
  assign adj_d    = AW'(pdiff_sh);
  assign det_abs  = det_d[DW-1] ? -det_d : det_d;
  assign recip    = det_q[DW-1] ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});

  // Restoring divide of 2^(2*FRAC) by |det|: the dividend has a single 1 in
  // its MSB, so only the first step shifts in a one.
  assign rem_sh = {rem_q[RW-2:0], (cnt_q == '0)};
  assign qbit   = (rem_sh >= {1'b0, dabs_q});
  assign rem_nx = qbit ? (rem_sh - {1'b0, dabs_q}) : rem_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      det_q       <= '0;
      dabs_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sing_pend_q <= 1'b0;
      sing_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        p_q[i]    <= '0;
        r_q[i]    <= '0;
        s_q[i]    <= '0;
        a_q[i]    <= '0;
        kres_q[i] <= '0;
        k_q[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coincident with the done pulse is not taken.
          if (bus.start && !done_q) begin
            p_q[0] <= bus.P11; p_q[1] <= bus.P12;
            p_q[2] <= bus.P21; p_q[3] <= bus.P22;
            r_q[0] <= bus.R11; r_q[1] <= bus.R12;
            r_q[2] <= bus.R21; r_q[3] <= bus.R22;
            busy_q  <= 1'b1;
            state_q <= SUM;
          end
        end
        SUM: begin
          for (int i = 0; i < 4; i++)
            s_q[i] <= SW'(p_q[i]) + SW'(r_q[i]);
          state_q <= DET;
        end
        DET: begin
          det_q <= det_d;
          cnt_q <= '0;
          if (det_d == '0) begin
            sing_pend_q <= 1'b1;
            for (int i = 0; i < 4; i++)
              kres_q[i] <= '0;
            state_q <= FIN;
          end else begin
            sing_pend_q <= 1'b0;
            dabs_q      <= det_abs;
            rem_q       <= '0;
            quo_q       <= '0;
            state_q     <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= {quo_q[QW-2:0], qbit};
          if (cnt_q == CW'(QW - 1)) begin
            cnt_q   <= '0;
            state_q <= ADJ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ADJ: begin
          a_q[cnt_q[1:0]] <= adj_d;
          if (cnt_q == CW'(3)) begin
            cnt_q   <= '0;
            state_q <= SCALE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SCALE: begin
          kres_q[cnt_q[1:0]] <= sat_n(kraw);
          if (cnt_q == CW'(3)) begin
            cnt_q   <= '0;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          for (int i = 0; i < 4; i++)
            k_q[i] <= kres_q[i];
          sing_q  <= sing_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sing = sing_q;
  assign bus.K11  = k_q[0];
  assign bus.K12  = k_q[1];
  assign bus.K21  = k_q[2];
  assign bus.K22  = k_q[3];

endmodule

// File: tb/tb_kgain_serial.sv
// -----------------------------------------------------------------------------
// tb_kgain_serial: directed and randomized bench for kgain_serial. Expected
// gains come from a plain-arithmetic matrix model of K = P * (P+R)^-1.
// -----------------------------------------------------------------------------
module tb_kgain_serial;
  localparam int N    = 20;
  localparam int FRAC = 10;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  longint mp [4];
  longint mr [4];
  longint ek [4];
  bit     es;

  kgain_if #(.N(N)) bus ();

  kgain_serial #(.N(N), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input int bits);
    logic signed [31:0] v;
    v = $urandom;
    return longint'(v >>> (32 - bits));
  endfunction

  // Reference: S = P + R, K = P * adj(S) / det(S) with the fixed-point
  // reciprocal floor(2^(2F)/|det|) and a final clamp to N bits.
  task automatic model();
    longint s [4];
    longint a [4];
    longint det, mag, recip, t, kmax, kmin;
    kmax = (longint'(1) <<< (N - 1)) - 1;
    kmin = -(longint'(1) <<< (N - 1));
    for (int i = 0; i < 4; i++) s[i] = mp[i] + mr[i];
    det = (s[0] * s[3] - s[1] * s[2]) >>> FRAC;
    if (det == 0) begin
      es = 1'b1;
      for (int i = 0; i < 4; i++) ek[i] = 0;
    end else begin
      es    = 1'b0;
      mag   = (longint'(1) <<< (2 * FRAC)) / (det < 0 ? -det : det);
      recip = (det < 0) ? -mag : mag;
      a[0] = (mp[0] * s[3] - mp[1] * s[2]) >>> FRAC;
      a[1] = (mp[1] * s[0] - mp[0] * s[1]) >>> FRAC;
      a[2] = (mp[2] * s[3] - mp[3] * s[2]) >>> FRAC;
      a[3] = (mp[3] * s[0] - mp[2] * s[1]) >>> FRAC;
      for (int i = 0; i < 4; i++) begin
        t = (a[i] * recip) >>> FRAC;
        ek[i] = (t > kmax) ? kmax : ((t < kmin) ? kmin : t);
      end
    end
  endtask

  task automatic drive_inputs();
    bus.P11 = N'(mp[0]); bus.P12 = N'(mp[1]);
    bus.P21 = N'(mp[2]); bus.P22 = N'(mp[3]);
    bus.R11 = N'(mr[0]); bus.R12 = N'(mr[1]);
    bus.R21 = N'(mr[2]); bus.R22 = N'(mr[3]);
  endtask

  task automatic scramble();
    bus.P11 = N'(rnd(N)); bus.P12 = N'(rnd(N));
    bus.P21 = N'(rnd(N)); bus.P22 = N'(rnd(N));
    bus.R11 = N'(rnd(N)); bus.R12 = N'(rnd(N));
    bus.R21 = N'(rnd(N)); bus.R22 = N'(rnd(N));
  endtask

  task automatic set_pr(input longint p0, p1, p2, p3, r0, r1, r2, r3);
    mp[0] = p0; mp[1] = p1; mp[2] = p2; mp[3] = p3;
    mr[0] = r0; mr[1] = r1; mr[2] = r2; mr[3] = r3;
  endtask

  // One complete request. inj_at > 0 pulses a foreign start that many cycles
  // into the run; coincide drives start during the done cycle.
  task automatic run_check(input string tag, input int inj_at, input bit coincide);
    int n;
    int lat;
    bit got;
    model();
    lat = es ? 3 : 2 * FRAC + 12;
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    chk({tag, "_busy_start"}, bus.busy, 1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      if (bus.done) got = 1'b1;
      else if (n == inj_at) begin
        scramble();
        bus.start = 1'b1;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_k11"}, bus.K11, ek[0]);
    chk({tag, "_k12"}, bus.K12, ek[1]);
    chk({tag, "_k21"}, bus.K21, ek[2]);
    chk({tag, "_k22"}, bus.K22, ek[3]);
    chk({tag, "_sing"}, bus.sing, es);
    chk({tag, "_busy_done"}, bus.busy, 0);
    if (coincide) begin
      scramble();
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    set_pr(0, 0, 0, 0, 0, 0, 0, 0);
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sing", bus.sing, 0);
    chk("rst_k11", bus.K11, 0);
    chk("rst_k22", bus.K22, 0);
    @(negedge clk);
    rst = 1'b0;

    // S = 2I, det = 4096, recip = 256
    set_pr(1024, 0, 0, 1024, 1024, 0, 0, 1024);
    run_check("diag2", 0, 1'b0);
    chk("diag2_k11_const", bus.K11, 512);

    // det = 8192, recip = 128
    set_pr(1024, 0, 0, 3072, 1024, 0, 0, 1024);
    run_check("diag_uneq", 0, 1'b0);
    chk("diag_uneq_k22_const", bus.K22, 768);

    // Negative determinant
    set_pr(0, 1024, 1024, 0, 0, 0, 0, 0);
    run_check("negdet", 0, 1'b0);
    chk("negdet_k11_const", bus.K11, 1024);

    // Singular, with a start driven during the done cycle
    set_pr(0, 0, 0, 0, 0, 0, 0, 0);
    run_check("singular", 0, 1'b1);
    chk("singular_sing_const", bus.sing, 1);

    set_pr(1024, 0, 0, 1024, 1024, 0, 0, 1024);
    run_check("unsing", 0, 1'b0);

    // Foreign start mid-run is ignored
    set_pr(1024, 0, 0, 3072, 1024, 0, 0, 1024);
    run_check("ignore_start", 10, 1'b0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("ignore_start_extra_done", ndone, 0);

    // Reset during a run
    set_pr(1024, 0, 0, 1024, 1024, 0, 0, 1024);
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_k11", bus.K11, 0);
    chk("midrst_k22", bus.K22, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    set_pr(0, 1024, 1024, 0, 0, 0, 0, 0);
    run_check("after_rst", 0, 1'b0);

    // Randomized: moderate values, then full-range values that can saturate
    for (int r = 0; r < 12; r++) begin
      int bits;
      bits = (r < 6) ? 13 : N;
      set_pr(rnd(bits), rnd(bits), rnd(bits), rnd(bits),
             rnd(bits), rnd(bits), rnd(bits), rnd(bits));
      run_check($sformatf("rand%0d", r), 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
